fetch_queue: RTL and testbench

Parametrised instruction fetch queue that sits between the PC/IF stage and the IF/ID register. It drives the instruction SRAM (one-cycle read latency) and buffers up to DEPTH fetched instructions with their PCs. It presents a valid/ready interface to decode, so ID stalls no longer freeze the SRAM request path. Control-flow redirects flush the queue, and misaligned fetch addresses are flagged as AdEL exceptions.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the PC/IF stage and IF/ID.
// Issues reads to a one-cycle-latency instruction SRAM and buffers up to
// DEPTH fetched instructions with their PCs. Decode sees a valid/ready head
// entry, so decode stalls never freeze the SRAM request path. A redirect
// flushes the queue and restarts fetch. A misaligned fetch address becomes
// an AdEL entry and halts fetch until the next redirect.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   redirect        flush queue, restart fetch at redirect_pc
//   redirect_pc     new fetch address, sampled while redirect=1
//   inst_sram_en    SRAM read request this cycle
//   inst_sram_addr  SRAM read address
//   inst_sram_rdata SRAM read data, valid the cycle after the request
//   out_valid       head entry valid
//   out_ready       decode accepts the head entry
//   out_inst        head instruction (0 for an AdEL entry)
//   out_pc          head PC
//   out_adel        head entry is an instruction-fetch address error
//   count           current occupancy
module fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC00000)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     inst_sram_en,
    output logic [ADDR_W-1:0]        inst_sram_addr,
    input  logic [DATA_W-1:0]        inst_sram_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_inst,
    output logic [ADDR_W-1:0]        out_pc,
    output logic                     out_adel,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_inst [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DEPTH-1:0]  mem_adel;

    logic [PW-1:0]     wr_ptr, rd_ptr, wr_idx;
    logic [ADDR_W-1:0] fetch_pc, inflight_pc, req_pc;
    logic              inflight, halted;

    logic              aligned, credit_ok, can_fetch, issue;
    logic              resp_push, adel_push, push, pop;
    logic [DATA_W-1:0] push_inst;
    logic [ADDR_W-1:0] push_pc;

    always_comb begin
        req_pc    = redirect ? redirect_pc : fetch_pc;
        aligned   = (req_pc[1:0] == 2'b00);
        // Entries already queued plus the one still in flight must fit;
        // a pop this cycle is not credited back until it has happened.
        credit_ok = ({1'b0, count} + (CW+1)'(inflight)) < DEPTH_C;
        can_fetch = reset & (redirect | ~halted) & (redirect | credit_ok);
        issue     = can_fetch & aligned;
        // A response arriving under a redirect belongs to the old path.
        resp_push = inflight & ~redirect;
        // The response takes the write slot; an AdEL push retries next cycle.
        adel_push = can_fetch & ~aligned & ~resp_push;
        push      = resp_push | adel_push;
        pop       = out_valid & out_ready;
        push_inst = resp_push ? inst_sram_rdata : '0;
        push_pc   = resp_push ? inflight_pc : req_pc;
        // A redirect flushes the queue, so its own push lands in slot 0.
        wr_idx    = redirect ? '0 : wr_ptr;
    end

    assign inst_sram_en   = issue;
    assign inst_sram_addr = req_pc;
    assign out_valid      = (count != '0);
    assign out_inst       = mem_inst[rd_ptr];
    assign out_pc         = mem_pc[rd_ptr];
    assign out_adel       = mem_adel[rd_ptr] & out_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halted      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mem_adel    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= req_pc;
                fetch_pc    <= req_pc + ADDR_W'(4);
            end
            if (push) begin
                mem_inst[wr_idx] <= push_inst;
                mem_pc[wr_idx]   <= push_pc;
                mem_adel[wr_idx] <= ~resp_push;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= PW'(adel_push);
                count  <= CW'(adel_push);
                halted <= adel_push;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (adel_push) halted <= 1'b1;
            end
        end
    end

    // The credit rule must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !redirect && count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset state, streaming, full-queue credit
// stop, redirect flush, AdEL halt, random back-pressure with a PC reference
// stream, and reset asserted mid-operation.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_adel;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_adel(out_adel), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // SRAM: one-cycle read latency, garbage when not requested.
    always @(posedge clk)
        inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hDEAD_BEEF;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        #2;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        total++; if (out_inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", out_inst); end
        total++; if (out_adel !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", out_adel); end
        total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", inst_sram_en); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        apply_reset();
        out_ready = 1'b1;
        reset     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sample();
            e = 32'hBFC0_0000 + 32'(4 * k);
            total++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== e) begin
                bad++; $display("FAIL stream_req k=%0d got en=%b addr=%h exp addr=%h", k, inst_sram_en, inst_sram_addr, e);
            end
            total++; if (out_valid !== (k >= 2)) begin
                bad++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, out_valid, (k >= 2));
            end
            if (k >= 2) begin
                e = 32'hBFC0_0000 + 32'(4 * (k - 2));
                total++; if (out_pc !== e || out_inst !== mem_word(e)) begin
                    bad++; $display("FAIL stream_head k=%0d got pc=%h inst=%h exp pc=%h inst=%h", k, out_pc, out_inst, e, mem_word(e));
                end
                total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count k=%0d got=%0d exp=1", k, count); end
            end
            next_cycle();
        end
    endtask

    task automatic test_full();
        int          n_req;
        logic [31:0] e;
        logic        first;
        apply_reset();
        reset = 1'b1;
        n_req = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (inst_sram_en) n_req++;
            next_cycle();
        end
        out_ready = 1'b1;
        e     = 32'hBFC0_0000;
        first = 1'b1;
        for (int j = 0; j < 8; j++) begin
            sample();
            if (j == 0) begin
                total++; if (n_req != 4) begin bad++; $display("FAIL full_reqs got=%0d exp=4", n_req); end
                total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
                total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL full_en got=%b exp=0", inst_sram_en); end
            end
            total++; if (out_valid !== 1'b1 || out_pc !== e) begin
                bad++; $display("FAIL full_drain j=%0d got valid=%b pc=%h exp pc=%h", j, out_valid, out_pc, e);
            end
            e = e + 32'd4;
            if (inst_sram_en && first) begin
                first = 1'b0;
                total++; if (inst_sram_addr !== 32'hBFC0_0010) begin
                    bad++; $display("FAIL full_resume got=%h exp=bfc00010", inst_sram_addr);
                end
            end
            next_cycle();
        end
        total++; if (first) begin bad++; $display("FAIL full_resume got=no_request exp=request"); end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        apply_reset();
        reset = 1'b1;
        repeat (4) next_cycle();
        redirect = 1'b1; redirect_pc = 32'h8000_1000;
        sample();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", count); end
        total++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h8000_1000) begin
            bad++; $display("FAIL redir_issue got en=%b addr=%h exp addr=80001000", inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        redirect = 1'b0;
        sample();
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL redir_flush got count=%0d valid=%b exp count=0 valid=0", count, out_valid);
        end
        next_cycle();
        sample();
        total++; if (count !== 3'd1 || out_pc !== 32'h8000_1000 || out_inst !== mem_word(32'h8000_1000)) begin
            bad++; $display("FAIL redir_head got count=%0d pc=%h inst=%h exp count=1 pc=80001000", count, out_pc, out_inst);
        end
        out_ready = 1'b1;
        e = 32'h8000_1004;
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            sample();
            total++; if (out_valid !== 1'b1 || out_pc !== e) begin
                bad++; $display("FAIL redir_stream j=%0d got valid=%b pc=%h exp pc=%h", j, out_valid, out_pc, e);
            end
            e = e + 32'd4;
        end
    endtask

    task automatic test_adel();
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h8000_0002; out_ready = 1'b0;
        sample();
        total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL adel_no_req got=%b exp=0", inst_sram_en); end
        next_cycle();
        redirect = 1'b0;
        sample();
        total++; if (count !== 3'd1 || out_valid !== 1'b1 || out_adel !== 1'b1) begin
            bad++; $display("FAIL adel_entry got count=%0d valid=%b adel=%b exp 1 1 1", count, out_valid, out_adel);
        end
        total++; if (out_pc !== 32'h8000_0002 || out_inst !== 32'h0) begin
            bad++; $display("FAIL adel_fields got pc=%h inst=%h exp pc=80000002 inst=0", out_pc, out_inst);
        end
        total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL adel_halt1 got=%b exp=0", inst_sram_en); end
        out_ready = 1'b1;
        next_cycle();
        sample();
        total++; if (count !== 3'd0 || inst_sram_en !== 1'b0) begin
            bad++; $display("FAIL adel_halt2 got count=%0d en=%b exp 0 0", count, inst_sram_en);
        end
        next_cycle();
        sample();
        total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL adel_halt3 got=%b exp=0", inst_sram_en); end
        next_cycle();
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        sample();
        total++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h8000_0100) begin
            bad++; $display("FAIL adel_resume got en=%b addr=%h exp addr=80000100", inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        redirect = 1'b0;
        sample();
        total++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h8000_0104) begin
            bad++; $display("FAIL adel_next got en=%b addr=%h exp addr=80000104", inst_sram_en, inst_sram_addr);
        end
        next_cycle();
        sample();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0100 || out_adel !== 1'b0 || out_inst !== mem_word(32'h8000_0100)) begin
            bad++; $display("FAIL adel_after got valid=%b pc=%h adel=%b inst=%h exp pc=80000100", out_valid, out_pc, out_adel, out_inst);
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        int          pops;
        apply_reset();
        reset = 1'b1;
        e     = 32'hBFC0_0000;
        pops  = 0;
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            redirect  = ((i % 97) == 50);
            if (redirect) redirect_pc = 32'h8000_0000 + (32'($urandom_range(0, 1023)) << 2);
            sample();
            total++; if (count > 3'd4) begin bad++; $display("FAIL rand_count i=%0d got=%0d exp<=4", i, count); end
            if (out_valid && out_ready) begin
                total++; if (out_pc !== e || out_inst !== mem_word(e) || out_adel !== 1'b0) begin
                    bad++; $display("FAIL rand_pop i=%0d got pc=%h inst=%h exp pc=%h inst=%h", i, out_pc, out_inst, e, mem_word(e));
                end
                e = e + 32'd4;
                pops++;
            end
            if (redirect) e = redirect_pc;
            next_cycle();
        end
        redirect = 1'b0;
        total++; if (pops < 200) begin bad++; $display("FAIL rand_throughput got pops=%0d exp>=200", pops); end
    endtask

    task automatic test_midreset();
        logic found;
        apply_reset();
        reset = 1'b1; out_ready = 1'b1;
        repeat (5) next_cycle();
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || count !== 3'd0 || inst_sram_en !== 1'b0) begin
            bad++; $display("FAIL midreset_clear got valid=%b count=%0d en=%b exp 0 0 0", out_valid, count, inst_sram_en);
        end
        next_cycle();
        reset = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (out_valid) begin
                found = 1'b1;
                total++; if (k != 2 || out_pc !== 32'hBFC0_0000) begin
                    bad++; $display("FAIL midreset_first got k=%0d pc=%h exp k=2 pc=bfc00000", k, out_pc);
                end
                break;
            end
            next_cycle();
        end
        total++; if (!found) begin bad++; $display("FAIL midreset_timeout got=no_valid exp=valid"); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_adel();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
